commit_rob: RTL and testbench

COMMIT_ROB -- requirements
Module: commit_rob

---
 rtl/commit_rob.sv | 99 +++++++++
 tb/tb_commit_rob.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_rob.sv
// In-order commit reorder buffer. It allocates entries at the tail, marks them done on
// wakeup, and retires up to RETIRE_W done entries per cycle from the head, reporting their old tags.
module commit_rob #(
  parameter int DEPTH      = 64,
  parameter int TAG_W      = 6,
  parameter int NUM_WAKEUP = 4,
  parameter int RETIRE_W   = 2,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enqueue_enable,
  input  logic [TAG_W-1:0]              enqueue_old_tag,
  output logic                          enqueue_ready,
  output logic [IDX_W-1:0]              next_rob_index,
  input  logic [NUM_WAKEUP-1:0]         wakeup_active,
  input  logic [NUM_WAKEUP*IDX_W-1:0]   wakeup_rob_index,
  output logic [RETIRE_W-1:0]           freed_tag_valid,
  output logic [RETIRE_W*TAG_W-1:0]     freed_tag,
  output logic [1:0]                    retire_count,
  output logic [IDX_W:0]                occupancy,
  output logic                          empty
);

  logic [IDX_W:0]                  head, tail;
  logic [DEPTH-1:0]                valid_q, done_q;
  logic [TAG_W-1:0]                old_tag_q [DEPTH];
  logic [IDX_W-1:0]                head_idx, tail_idx;
  logic                            full, enq_fire, run;
  logic [1:0]                      retire_k;
  logic [RETIRE_W-1:0][IDX_W-1:0]  slot_idx;
  logic [RETIRE_W-1:0]             retire_mask, freed_valid_c;
  logic [RETIRE_W*TAG_W-1:0]       freed_tag_c;

  assign head_idx       = head[IDX_W-1:0];
  assign tail_idx       = tail[IDX_W-1:0];
  assign full           = (head[IDX_W] != tail[IDX_W]) && (head_idx == tail_idx);
  assign enqueue_ready  = !full;
  assign next_rob_index = tail_idx;
  assign occupancy      = tail - head;
  assign empty          = (tail == head);
  assign enq_fire       = enqueue_enable && !full;

  // Retirement looks only at registered done bits, so a wakeup retires one edge later at the earliest.
  always_comb begin
    retire_k      = '0;
    run           = 1'b1;
    slot_idx      = '0;
    retire_mask   = '0;
    freed_valid_c = '0;
    freed_tag_c   = '0;
    for (int s = 0; s < RETIRE_W; s++) begin
      slot_idx[s]    = head_idx + IDX_W'(s);
      run            = run && valid_q[slot_idx[s]] && done_q[slot_idx[s]]
                       && (occupancy > (IDX_W+1)'(s));
      retire_mask[s] = run;
      if (run) begin
        retire_k                       = retire_k + 2'd1;
        freed_tag_c[s*TAG_W +: TAG_W]  = old_tag_q[slot_idx[s]];
        freed_valid_c[s]               = (old_tag_q[slot_idx[s]] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head            <= '0;
      tail            <= '0;
      valid_q         <= '0;
      done_q          <= '0;
      freed_tag_valid <= '0;
      freed_tag       <= '0;
      retire_count    <= '0;
    end else begin
      for (int p = 0; p < NUM_WAKEUP; p++) begin
        if (wakeup_active[p] && valid_q[wakeup_rob_index[p*IDX_W +: IDX_W]])
          done_q[wakeup_rob_index[p*IDX_W +: IDX_W]] <= 1'b1;
      end
      // Clearing retired slots comes after the wakeup writes so it always wins.
      for (int s = 0; s < RETIRE_W; s++) begin
        if (retire_mask[s]) begin
          valid_q[slot_idx[s]] <= 1'b0;
          done_q[slot_idx[s]]  <= 1'b0;
        end
      end
      if (enq_fire) begin
        valid_q[tail_idx]   <= 1'b1;
        done_q[tail_idx]    <= 1'b0;
        old_tag_q[tail_idx] <= enqueue_old_tag;
        tail                <= tail + 1'b1;
      end
      head            <= head + (IDX_W+1)'(retire_k);
      retire_count    <= retire_k;
      freed_tag_valid <= freed_valid_c;
      freed_tag       <= freed_tag_c;
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Self-checking bench for commit_rob (DEPTH=4). Directed scenarios use hand-derived constants;
// the random phase is compared against a queue-based model of live entries.
module tb_commit_rob;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int NW    = 4;
  localparam int RW    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enqueue_enable;
  logic [5:0]  enqueue_old_tag;
  logic        enqueue_ready;
  logic [1:0]  next_rob_index;
  logic [3:0]  wakeup_active;
  logic [7:0]  wakeup_rob_index;
  logic [1:0]  freed_tag_valid;
  logic [11:0] freed_tag;
  logic [1:0]  retire_count;
  logic [2:0]  occupancy;
  logic        empty;

  commit_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WAKEUP(NW), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset),
    .enqueue_enable(enqueue_enable), .enqueue_old_tag(enqueue_old_tag),
    .enqueue_ready(enqueue_ready), .next_rob_index(next_rob_index),
    .wakeup_active(wakeup_active), .wakeup_rob_index(wakeup_rob_index),
    .freed_tag_valid(freed_tag_valid), .freed_tag(freed_tag),
    .retire_count(retire_count), .occupancy(occupancy), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int tag; bit done; } ent_t;
  ent_t q[$];
  int   tail_cnt;
  int   errors = 0;
  int   checks = 0;
  logic [1:0]  exp_k;
  logic [1:0]  exp_fv;
  logic [11:0] exp_ft;

  // Drives one cycle of inputs and advances the model by the rules of in-order commit.
  task automatic step(input bit en, input int tag, input logic [3:0] wa, input logic [7:0] wi);
    int k;
    bit was_full;
    ent_t e;
    enqueue_enable   = en;
    enqueue_old_tag  = tag[5:0];
    wakeup_active    = wa;
    wakeup_rob_index = wi;
    k = 0;
    while (k < RW && k < q.size() && q[k].done) k++;
    exp_k  = 2'(k);
    exp_fv = '0;
    exp_ft = '0;
    for (int s = 0; s < k; s++) begin
      exp_ft[s*6 +: 6] = q[s].tag[5:0];
      exp_fv[s]        = (q[s].tag != 0);
    end
    for (int p = 0; p < NW; p++)
      if (wa[p])
        for (int j = k; j < q.size(); j++)
          if (q[j].idx == int'(wi[p*2 +: 2])) q[j].done = 1'b1;
    was_full = (q.size() >= DEPTH);
    repeat (k) void'(q.pop_front());
    if (en && !was_full) begin
      e.idx = tail_cnt % DEPTH; e.tag = tag; e.done = 1'b0;
      q.push_back(e);
      tail_cnt = (tail_cnt + 1) % (2*DEPTH);
    end
    @(posedge clk); #1;
    enqueue_enable = 1'b0;
    wakeup_active  = '0;
  endtask

  task automatic do_reset(input bit en, input logic [3:0] wa, input logic [7:0] wi);
    enqueue_enable = en; enqueue_old_tag = 6'd30; wakeup_active = wa; wakeup_rob_index = wi;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; enqueue_enable = 1'b0; wakeup_active = '0;
    q.delete();
    tail_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 4'b0, 8'h0);
    checks++; if ({enqueue_ready, empty} !== 2'b11) begin errors++; $display("FAIL reset_ready_empty: got %b want 11", {enqueue_ready, empty}); end
    checks++; if (occupancy !== 3'd0 || next_rob_index !== 2'd0) begin errors++; $display("FAIL reset_occ_next: got occ=%0d next=%0d want 0 0", occupancy, next_rob_index); end
    checks++; if (retire_count !== 2'd0 || freed_tag_valid !== 2'b00 || freed_tag !== 12'd0) begin errors++; $display("FAIL reset_retire: got k=%0d fv=%b ft=%h want 0 00 000", retire_count, freed_tag_valid, freed_tag); end
  endtask

  task automatic test_basic();
    step(1, 5, 4'b0, 8'h0);
    checks++; if (next_rob_index !== 2'd1) begin errors++; $display("FAIL enq5_next: got %0d want 1", next_rob_index); end
    step(1, 7, 4'b0, 8'h0);
    checks++; if (next_rob_index !== 2'd2) begin errors++; $display("FAIL enq7_next: got %0d want 2", next_rob_index); end
    step(1, 9, 4'b0, 8'h0);
    checks++; if (next_rob_index !== 2'd3 || occupancy !== 3'd3) begin errors++; $display("FAIL enq9: got next=%0d occ=%0d want 3 3", next_rob_index, occupancy); end
    step(0, 0, 4'b0011, 8'b00_00_10_01);
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd0 || occupancy !== 3'd3) begin errors++; $display("FAIL head_blocked: got k=%0d occ=%0d want 0 3", retire_count, occupancy); end
    step(0, 0, 4'b0001, 8'h00);
    checks++; if (retire_count !== 2'd0) begin errors++; $display("FAIL wake_same_edge: got k=%0d want 0", retire_count); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd2 || freed_tag !== {6'd7, 6'd5} || freed_tag_valid !== 2'b11) begin errors++; $display("FAIL retire_5_7: got k=%0d ft=%h fv=%b want 2 %h 11", retire_count, freed_tag, freed_tag_valid, {6'd7, 6'd5}); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd1 || freed_tag !== {6'd0, 6'd9} || freed_tag_valid !== 2'b01 || empty !== 1'b1) begin errors++; $display("FAIL retire_9: got k=%0d ft=%h fv=%b empty=%b want 1 009 01 1", retire_count, freed_tag, freed_tag_valid, empty); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd0 || freed_tag_valid !== 2'b00 || freed_tag !== 12'd0) begin errors++; $display("FAIL pulse_clear: got k=%0d fv=%b ft=%h want 0 00 000", retire_count, freed_tag_valid, freed_tag); end
  endtask

  task automatic test_zero_tag();
    step(1, 0, 4'b0, 8'h0);
    step(0, 0, 4'b0001, 8'h03);
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd1 || freed_tag_valid !== 2'b00 || freed_tag !== 12'd0) begin errors++; $display("FAIL zero_tag: got k=%0d fv=%b ft=%h want 1 00 000", retire_count, freed_tag_valid, freed_tag); end
  endtask

  task automatic test_full_wrap();
    step(1, 11, 4'b0, 8'h0);
    step(1, 12, 4'b0, 8'h0);
    step(1, 13, 4'b0, 8'h0);
    step(1, 14, 4'b0, 8'h0);
    checks++; if (enqueue_ready !== 1'b0 || occupancy !== 3'd4 || next_rob_index !== 2'd0) begin errors++; $display("FAIL full: got ready=%b occ=%0d next=%0d want 0 4 0", enqueue_ready, occupancy, next_rob_index); end
    step(1, 15, 4'b0, 8'h0);
    checks++; if (occupancy !== 3'd4 || next_rob_index !== 2'd0) begin errors++; $display("FAIL full_ignore: got occ=%0d next=%0d want 4 0", occupancy, next_rob_index); end
    step(0, 0, 4'b0011, 8'h04);
    step(1, 15, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd2 || freed_tag !== {6'd12, 6'd11} || occupancy !== 3'd2 || next_rob_index !== 2'd0) begin errors++; $display("FAIL retire_while_full: got k=%0d ft=%h occ=%0d next=%0d want 2 %h 2 0", retire_count, freed_tag, occupancy, next_rob_index, {6'd12, 6'd11}); end
    step(1, 16, 4'b0, 8'h0);
    checks++; if (next_rob_index !== 2'd1) begin errors++; $display("FAIL wrap_idx0: got next=%0d want 1", next_rob_index); end
    step(1, 17, 4'b0, 8'h0);
    checks++; if (next_rob_index !== 2'd2 || occupancy !== 3'd4 || enqueue_ready !== 1'b0) begin errors++; $display("FAIL wrap_full: got next=%0d occ=%0d ready=%b want 2 4 0", next_rob_index, occupancy, enqueue_ready); end
  endtask

  task automatic test_multi_wakeup();
    step(0, 0, 4'b1111, 8'hE4);
    checks++; if (retire_count !== 2'd0) begin errors++; $display("FAIL multi_same_edge: got k=%0d want 0", retire_count); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd2 || freed_tag !== {6'd14, 6'd13}) begin errors++; $display("FAIL multi_r1: got k=%0d ft=%h want 2 %h", retire_count, freed_tag, {6'd14, 6'd13}); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd2 || freed_tag !== {6'd17, 6'd16} || empty !== 1'b1) begin errors++; $display("FAIL multi_r2_wrap: got k=%0d ft=%h empty=%b want 2 %h 1", retire_count, freed_tag, empty, {6'd17, 6'd16}); end
    step(1, 20, 4'b0, 8'h0);
    step(0, 0, 4'b0100, 8'h30);
    step(0, 0, 4'b0, 8'h0);
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd0 || occupancy !== 3'd1) begin errors++; $display("FAIL invalid_wake: got k=%0d occ=%0d want 0 1", retire_count, occupancy); end
    step(1, 21, 4'b0011, 8'h0E);
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd1 || freed_tag !== {6'd0, 6'd20}) begin errors++; $display("FAIL wake_with_enq: got k=%0d ft=%h want 1 014", retire_count, freed_tag); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd0 || occupancy !== 3'd1) begin errors++; $display("FAIL enq_wake_ignored: got k=%0d occ=%0d want 0 1", retire_count, occupancy); end
  endtask

  task automatic test_reset_midop();
    step(1, 22, 4'b0, 8'h0);
    step(1, 23, 4'b0, 8'h0);
    step(0, 0, 4'b0011, 8'h04);
    step(0, 0, 4'b0, 8'h0);
    checks++; if (retire_count !== 2'd0 || occupancy !== 3'd3) begin errors++; $display("FAIL pre_reset: got k=%0d occ=%0d want 0 3", retire_count, occupancy); end
    do_reset(1'b1, 4'b1111, 8'hE4);
    checks++; if (freed_tag_valid !== 2'b00 || retire_count !== 2'd0 || empty !== 1'b1 || occupancy !== 3'd0 || next_rob_index !== 2'd0) begin errors++; $display("FAIL midop_reset: got fv=%b k=%0d empty=%b occ=%0d next=%0d want 00 0 1 0 0", freed_tag_valid, retire_count, empty, occupancy, next_rob_index); end
    step(0, 0, 4'b0, 8'h0);
    checks++; if (freed_tag_valid !== 2'b00 || retire_count !== 2'd0 || empty !== 1'b1) begin errors++; $display("FAIL post_reset: got fv=%b k=%0d empty=%b want 00 0 1", freed_tag_valid, retire_count, empty); end
  endtask

  task automatic test_random();
    logic [2:0] e_occ;
    logic [1:0] e_next;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), int'($urandom_range(0, 63)), 4'($urandom), 8'($urandom));
      e_occ  = 3'(q.size());
      e_next = 2'(tail_cnt % DEPTH);
      checks++;
      if ({retire_count, freed_tag_valid, freed_tag} !== {exp_k, exp_fv, exp_ft}
          || occupancy !== e_occ || next_rob_index !== e_next
          || empty !== (q.size() == 0) || enqueue_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL random_%0d: got k=%0d fv=%b ft=%h occ=%0d next=%0d empty=%b ready=%b want k=%0d fv=%b ft=%h occ=%0d next=%0d",
                 i, retire_count, freed_tag_valid, freed_tag, occupancy, next_rob_index, empty, enqueue_ready,
                 exp_k, exp_fv, exp_ft, e_occ, e_next);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enqueue_enable = 1'b0; enqueue_old_tag = '0;
    wakeup_active = '0; wakeup_rob_index = '0; tail_cnt = 0;
    test_reset();
    test_basic();
    test_zero_tag();
    test_full_wrap();
    test_multi_wakeup();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
